hub75_frame_buffer: RTL and testbench

//  Double-buffered pixel store that sits directly upstream of the HUB75 matrix scan driver.
//  A pattern or graphics source writes single pixels into the back bank. The scan driver

---
 rtl/hub75_frame_buffer.sv | 212 +++++++++++++++++++++
 tb/tb_hub75_frame_buffer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_frame_buffer.sv
// hub75_frame_buffer
//
// Purpose:
//   Double-buffered 3-bit-per-pixel store feeding a HUB75 matrix scan driver.
//   A pixel source writes single pixels into the back bank. The scan driver
//   reads top-half / bottom-half pixel pairs from the front bank. Banks swap
//   only on a frame boundary (frame_sync), so a half-drawn frame is never shown.
//
// Configuration macro:
//   CLEAR_ON_SWAP_EN - when defined, a clear FSM zeroes the new back bank after
//                      every swap and after reset. wr_ready stays low while it runs.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   wr_valid/ready   pixel write handshake; wr_x, wr_y, wr_rgb carry the pixel
//   wr_commit        frame complete, request a bank swap (accepted when wr_ready)
//   rd_en            scan driver read strobe; rd_row/rd_col address the pair
//   rd_valid         rd_top/rd_bot valid (one cycle after rd_en)
//   rd_top, rd_bot   {R0,G0,B0} at (col,row) and {R1,G1,B1} at (col,row+ROWS/2)
//   frame_sync       end-of-frame pulse from the scan driver
//   swap_pend        a commit was accepted and the swap has not happened yet
//   front_bank       index of the bank being displayed

module hub75_frame_buffer #(
   parameter int COLS  = 64,
   parameter int ROWS  = 32,
   parameter int COL_W = 6,
   parameter int ROW_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [COL_W-1:0] wr_x,
   input  logic [ROW_W-1:0] wr_y,
   input  logic [2:0]       wr_rgb,
   input  logic             wr_commit,
   input  logic             rd_en,
   input  logic [ROW_W-2:0] rd_row,
   input  logic [COL_W-1:0] rd_col,
   output logic             rd_valid,
   output logic [2:0]       rd_top,
   output logic [2:0]       rd_bot,
   input  logic             frame_sync,
   output logic             swap_pend,
   output logic             front_bank
);

   // Per-bank address is {row, col}; full address adds the bank bit on top.
   localparam int HALF_W = (ROW_W - 1) + COL_W;
   localparam int ADDR_W = HALF_W + 1;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic [2:0] top_mem [DEPTH];
   logic [2:0] bot_mem [DEPTH];

   logic       front_bank_q, front_bank_d;
   logic       swap_pend_q,  swap_pend_d;
   logic       rd_valid_q,   rd_valid_d;
   logic [2:0] rd_top_q,     rd_top_d;
   logic [2:0] rd_bot_q,     rd_bot_d;

   logic              wr_fire;
   logic              commit_fire;
   logic              swap_fire;
   logic              coord_ok;
   logic              top_we;
   logic              bot_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [2:0]        mem_wdata;
   logic [ADDR_W-1:0] rd_addr;

   assign wr_fire     = wr_valid & wr_ready;
   assign commit_fire = wr_commit & wr_ready;
   // swap_pend_q is 0 whenever a commit can be accepted, so a frame_sync in
   // the commit cycle cannot swap; it has to wait for the next one.
   assign swap_fire   = frame_sync & swap_pend_q;

   // Guard for panel sizes whose coordinate fields are wider than the panel.
   assign coord_ok = ({1'b0, wr_x} < (COL_W + 1)'(COLS)) &&
                     ({1'b0, wr_y} < (ROW_W + 1)'(ROWS));

`ifdef CLEAR_ON_SWAP_EN
   typedef enum logic {
      IDLE,
      CLEAR
   } clr_state_e;

   clr_state_e        clr_state_q, clr_state_d;
   logic [HALF_W-1:0] clr_cnt_q,   clr_cnt_d;
   logic              clear_busy;

   assign clear_busy = (clr_state_q == CLEAR);
   assign wr_ready   = ~swap_pend_q & ~clear_busy;

   // Clear sweep: one address of both arrays of the back bank per cycle.
   always_comb begin
      clr_state_d = clr_state_q;
      clr_cnt_d   = clr_cnt_q;
      case (clr_state_q)
         IDLE: begin
            if (swap_fire) begin
               clr_state_d = CLEAR;
               clr_cnt_d   = '0;
            end
         end
         CLEAR: begin
            clr_cnt_d = clr_cnt_q + HALF_W'(1);
            if (clr_cnt_q == '1) begin
               clr_state_d = IDLE;
            end
         end
         default: begin
            clr_state_d = IDLE;
         end
      endcase
   end

   // Reset lands directly in CLEAR so the first back bank starts zeroed;
   // a reset during a sweep restarts it from address 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_state_q <= CLEAR;
         clr_cnt_q   <= '0;
      end else begin
         clr_state_q <= clr_state_d;
         clr_cnt_q   <= clr_cnt_d;
      end
   end
`else
   assign wr_ready = ~swap_pend_q;
`endif

   // Bank swap bookkeeping.
   always_comb begin
      swap_pend_d  = swap_pend_q;
      front_bank_d = front_bank_q;
      if (commit_fire) begin
         swap_pend_d = 1'b1;
      end else if (swap_fire) begin
         swap_pend_d  = 1'b0;
         front_bank_d = ~front_bank_q;
      end
   end

   // Write port: always the back bank, so it never collides with scan reads.
   // A pixel accepted alongside a commit still uses the pre-swap back bank.
   always_comb begin
      top_we    = 1'b0;
      bot_we    = 1'b0;
      mem_waddr = {~front_bank_q, wr_y[ROW_W-2:0], wr_x};
      mem_wdata = wr_rgb;
`ifdef CLEAR_ON_SWAP_EN
      if (clear_busy) begin
         top_we    = 1'b1;
         bot_we    = 1'b1;
         mem_waddr = {~front_bank_q, clr_cnt_q};
         mem_wdata = 3'b000;
      end else
`endif
      if (wr_fire && coord_ok) begin
         top_we = ~wr_y[ROW_W-1];
         bot_we = wr_y[ROW_W-1];
      end
   end

   always_ff @(posedge clk) begin
      if (top_we) begin
         top_mem[mem_waddr] <= mem_wdata;
      end
      if (bot_we) begin
         bot_mem[mem_waddr] <= mem_wdata;
      end
   end

   // The bank bit is captured at issue time, so a swap on the same edge does
   // not change what is returned.
   assign rd_addr = {front_bank_q, rd_row, rd_col};

   always_comb begin
      rd_valid_d = rd_en;
      rd_top_d   = rd_top_q;
      rd_bot_d   = rd_bot_q;
      if (rd_en) begin
         rd_top_d = top_mem[rd_addr];
         rd_bot_d = bot_mem[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         front_bank_q <= 1'b0;
         swap_pend_q  <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_top_q     <= 3'b000;
         rd_bot_q     <= 3'b000;
      end else begin
         front_bank_q <= front_bank_d;
         swap_pend_q  <= swap_pend_d;
         rd_valid_q   <= rd_valid_d;
         rd_top_q     <= rd_top_d;
         rd_bot_q     <= rd_bot_d;
      end
   end

   assign rd_valid   = rd_valid_q;
   assign rd_top     = rd_top_q;
   assign rd_bot     = rd_bot_q;
   assign swap_pend  = swap_pend_q;
   assign front_bank = front_bank_q;

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// tb_hub75_frame_buffer
//
// Directed bench for hub75_frame_buffer at default geometry (64x32).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they show the result of the edge just taken.
// With CLEAR_ON_SWAP_EN defined, the clear-sweep scenario is also run.

module tb_hub75_frame_buffer;

   localparam int COLS  = 64;
   localparam int ROWS  = 32;
   localparam int COL_W = 6;
   localparam int ROW_W = 5;
`ifdef CLEAR_ON_SWAP_EN
   localparam int CLEAR_CYC = 1024;
`else
   localparam int CLEAR_CYC = 0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_valid;
   logic             wr_ready;
   logic [COL_W-1:0] wr_x;
   logic [ROW_W-1:0] wr_y;
   logic [2:0]       wr_rgb;
   logic             wr_commit;
   logic             rd_en;
   logic [ROW_W-2:0] rd_row;
   logic [COL_W-1:0] rd_col;
   logic             rd_valid;
   logic [2:0]       rd_top;
   logic [2:0]       rd_bot;
   logic             frame_sync;
   logic             swap_pend;
   logic             front_bank;

   int checks   = 0;
   int failures = 0;

   hub75_frame_buffer #(
      .COLS (COLS),
      .ROWS (ROWS),
      .COL_W(COL_W),
      .ROW_W(ROW_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .wr_rgb    (wr_rgb),
      .wr_commit (wr_commit),
      .rd_en     (rd_en),
      .rd_row    (rd_row),
      .rd_col    (rd_col),
      .rd_valid  (rd_valid),
      .rd_top    (rd_top),
      .rd_bot    (rd_bot),
      .frame_sync(frame_sync),
      .swap_pend (swap_pend),
      .front_bank(front_bank)
   );

   always #5 clk = ~clk;

   // Hard stop in case something upstream loops forever.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts cycles until wr_ready rises, bounded so a stuck DUT still ends.
   task automatic wait_ready(output int n);
      n = 0;
      while (wr_ready !== 1'b1 && n < 3000) begin
         tick();
         n++;
      end
   endtask

   task automatic write_px(input int x, input int y, input logic [2:0] rgb);
      wr_valid = 1'b1;
      wr_x     = COL_W'(x);
      wr_y     = ROW_W'(y);
      wr_rgb   = rgb;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic issue_read(input int row, input int col);
      rd_en  = 1'b1;
      rd_row = (ROW_W - 1)'(row);
      rd_col = COL_W'(col);
      tick();
      rd_en = 1'b0;
   endtask

   // Commit, then frame_sync, then wait out any clear; returns wr_ready-low cycles.
   task automatic do_swap(output int n);
      wr_commit = 1'b1;
      tick();
      wr_commit  = 1'b0;
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      wait_ready(n);
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (front_bank !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_front: got %0b expected 0", front_bank);
      end
      checks++;
      if (swap_pend !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_swap_pend: got %0b expected 0", swap_pend);
      end
      checks++;
      if (rd_valid !== 1'b0 || rd_top !== 3'b000 || rd_bot !== 3'b000) begin
         failures++;
         $display("[TB] FAIL reset_read: got valid=%0b top=%b bot=%b expected 0/000/000",
                  rd_valid, rd_top, rd_bot);
      end
      wait_ready(n);
      checks++;
      if (n != CLEAR_CYC) begin
         failures++;
         $display("[TB] FAIL reset_ready_delay: got %0d cycles expected %0d", n, CLEAR_CYC);
      end
   endtask

   task automatic test_write_read();
      int n;
      write_px(3, 2, 3'b101);
      write_px(3, 18, 3'b011);
      wr_commit = 1'b1;
      tick();
      wr_commit = 1'b0;
      checks++;
      if (swap_pend !== 1'b1 || wr_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL commit_pending: got pend=%0b ready=%0b expected 1/0",
                  swap_pend, wr_ready);
      end
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      checks++;
      if (front_bank !== 1'b1 || swap_pend !== 1'b0) begin
         failures++;
         $display("[TB] FAIL first_swap: got front=%0b pend=%0b expected 1/0",
                  front_bank, swap_pend);
      end
      wait_ready(n);
      checks++;
      if (n != CLEAR_CYC) begin
         failures++;
         $display("[TB] FAIL swap_ready_delay: got %0d expected %0d", n, CLEAR_CYC);
      end
      issue_read(2, 3);
      checks++;
      if (rd_valid !== 1'b1 || rd_top !== 3'b101 || rd_bot !== 3'b011) begin
         failures++;
         $display("[TB] FAIL read_pair: got valid=%0b top=%b bot=%b expected 1/101/011",
                  rd_valid, rd_top, rd_bot);
      end
      tick();
      checks++;
      if (rd_valid !== 1'b0 || rd_top !== 3'b101 || rd_bot !== 3'b011) begin
         failures++;
         $display("[TB] FAIL read_hold: got valid=%0b top=%b bot=%b expected 0/101/011",
                  rd_valid, rd_top, rd_bot);
      end
   endtask

   // front=1 on entry, so bank 0 is back.
   task automatic test_commit_blocks();
      int n;
      int low;
      write_px(5, 1, 3'b001);
      wr_commit = 1'b1;
      tick();
      wr_commit = 1'b0;
      wr_valid  = 1'b1;
      wr_x      = COL_W'(5);
      wr_y      = ROW_W'(1);
      wr_rgb    = 3'b110;
      low = 0;
      for (int i = 0; i < 3; i++) begin
         if (wr_ready === 1'b0) low++;
         tick();
      end
      checks++;
      if (low != 3) begin
         failures++;
         $display("[TB] FAIL blocked_ready: got %0d low cycles expected 3", low);
      end
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      wr_valid   = 1'b0;
      checks++;
      if (front_bank !== 1'b0 || wr_ready !== (CLEAR_CYC == 0)) begin
         failures++;
         $display("[TB] FAIL blocked_swap: got front=%0b ready=%0b expected 0/%0b",
                  front_bank, wr_ready, CLEAR_CYC == 0);
      end
      wait_ready(n);
      issue_read(1, 5);
      checks++;
      if (rd_top !== 3'b001) begin
         failures++;
         $display("[TB] FAIL blocked_write_dropped: got %b expected 001", rd_top);
      end
   endtask

   // front=0 on entry.
   task automatic test_commit_sync_same();
      int n;
      wr_commit  = 1'b1;
      frame_sync = 1'b1;
      tick();
      wr_commit  = 1'b0;
      frame_sync = 1'b0;
      checks++;
      if (front_bank !== 1'b0 || swap_pend !== 1'b1) begin
         failures++;
         $display("[TB] FAIL same_cycle_no_swap: got front=%0b pend=%0b expected 0/1",
                  front_bank, swap_pend);
      end
      tick();
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      checks++;
      if (front_bank !== 1'b1 || swap_pend !== 1'b0) begin
         failures++;
         $display("[TB] FAIL same_cycle_late_swap: got front=%0b pend=%0b expected 1/0",
                  front_bank, swap_pend);
      end
      wait_ready(n);
   endtask

   // front=1 on entry.
   task automatic test_read_at_swap();
      int n;
      write_px(7, 4, 3'b110);
      do_swap(n);
      write_px(7, 4, 3'b011);
      wr_commit = 1'b1;
      tick();
      wr_commit  = 1'b0;
      frame_sync = 1'b1;
      rd_en      = 1'b1;
      rd_row     = (ROW_W - 1)'(4);
      rd_col     = COL_W'(7);
      tick();
      frame_sync = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || rd_top !== 3'b110 || front_bank !== 1'b1) begin
         failures++;
         $display("[TB] FAIL read_at_swap: got valid=%0b top=%b front=%0b expected 1/110/1",
                  rd_valid, rd_top, front_bank);
      end
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_top !== 3'b011) begin
         failures++;
         $display("[TB] FAIL read_after_swap: got %b expected 011", rd_top);
      end
      wait_ready(n);
   endtask

   // front=1 on entry; reset with a pending swap and an in-flight read.
   task automatic test_mid_reset();
      int n;
      wr_commit = 1'b1;
      tick();
      wr_commit = 1'b0;
      checks++;
      if (swap_pend !== 1'b1 || front_bank !== 1'b1) begin
         failures++;
         $display("[TB] FAIL pre_reset: got pend=%0b front=%0b expected 1/1",
                  swap_pend, front_bank);
      end
      rst    = 1'b1;
      rd_en  = 1'b1;
      rd_row = (ROW_W - 1)'(4);
      rd_col = COL_W'(7);
      tick();
      rst   = 1'b0;
      rd_en = 1'b0;
      checks++;
      if (front_bank !== 1'b0 || swap_pend !== 1'b0 || rd_valid !== 1'b0 ||
          rd_top !== 3'b000) begin
         failures++;
         $display("[TB] FAIL mid_reset: got front=%0b pend=%0b valid=%0b top=%b expected 0/0/0/000",
                  front_bank, swap_pend, rd_valid, rd_top);
      end
      wait_ready(n);
      checks++;
      if (n != CLEAR_CYC) begin
         failures++;
         $display("[TB] FAIL mid_reset_ready: got %0d expected %0d", n, CLEAR_CYC);
      end
   endtask

`ifdef CLEAR_ON_SWAP_EN
   // front=0 on entry, bank 1 is back and already cleared.
   task automatic test_clear();
      int n;
      int bad;
      for (int y = 0; y < ROWS; y++) begin
         for (int x = 0; x < COLS; x++) begin
            write_px(x, y, 3'b111);
         end
      end
      do_swap(n);
      checks++;
      if (n != 1024 || front_bank !== 1'b1) begin
         failures++;
         $display("[TB] FAIL clear_swap1: got %0d cycles front=%0b expected 1024/1", n, front_bank);
      end
      issue_read(9, 40);
      checks++;
      if (rd_top !== 3'b111 || rd_bot !== 3'b111) begin
         failures++;
         $display("[TB] FAIL filled_bank: got top=%b bot=%b expected 111/111", rd_top, rd_bot);
      end
      do_swap(n);
      checks++;
      if (n != 1024) begin
         failures++;
         $display("[TB] FAIL clear_swap2: got %0d cycles expected 1024", n);
      end
      do_swap(n);
      bad = 0;
      for (int r = 0; r < ROWS / 2; r++) begin
         for (int c = 0; c < COLS; c++) begin
            issue_read(r, c);
            if (rd_top !== 3'b000 || rd_bot !== 3'b000 || rd_valid !== 1'b1) bad++;
         end
      end
      checks++;
      if (bad != 0 || front_bank !== 1'b1) begin
         failures++;
         $display("[TB] FAIL cleared_bank: got %0d nonzero reads front=%0b expected 0/1",
                  bad, front_bank);
      end
   endtask
`endif

   initial begin
      rst        = 1'b1;
      wr_valid   = 1'b0;
      wr_x       = '0;
      wr_y       = '0;
      wr_rgb     = 3'b000;
      wr_commit  = 1'b0;
      rd_en      = 1'b0;
      rd_row     = '0;
      rd_col     = '0;
      frame_sync = 1'b0;
      #1;
      test_reset();
      test_write_read();
      test_commit_blocks();
      test_commit_sync_same();
      test_read_at_swap();
      test_mid_reset();
`ifdef CLEAR_ON_SWAP_EN
      test_clear();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
